// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: groups the serial input side (strobe, bit) and the
// valid/ready output buffer of serial_frame_rx into one bundle.
//
// Handshake: a word moves from the receiver to the consumer on every rising
// clock edge where data_vld and rdy are both 1. data_out and par_err are held
// stable while data_vld is 1 and no transfer has happened yet.
//
// Signals:
//   s_en     bit strobe, s_in is only looked at while it is 1
//   s_in     serial bit
//   rdy      consumer ready
//   data_out received word
//   data_vld output buffer holds a word
//   par_err  parity status of the held word
//   frm_err  one-cycle pulse, stop bit was 0
//   overrun  one-cycle pulse, good frame dropped because buffer was full
//   busy     receiver is inside a frame
// Modports: master = stimulus / consumer side, slave = receiver.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              s_en;
    logic              s_in;
    logic              rdy;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              par_err;
    logic              frm_err;
    logic              overrun;
    logic              busy;

    modport master (
        output s_en, s_in, rdy,
        input  data_out, data_vld, par_err, frm_err, overrun, busy
    );

    modport slave (
        input  s_en, s_in, rdy,
        output data_out, data_vld, par_err, frm_err, overrun, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: rebuilds parallel words from a strobed serial stream.
// Frame (in strobed samples): start 0, DATA_W data bits LSB first, even
// parity bit, stop 1. Accepted words go to a one-entry valid/ready buffer;
// words with bad parity are still delivered, flagged by par_err.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        serial_frame_rx_if slave modport (see interface header)
//   dbg_state  current FSM state (0 IDLE, 1 DATA, 2 PAR, 3 STOP)
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    serial_frame_rx_if.slave  bus,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              par_err;
    logic              frm_err;
    logic              overrun;
    logic              busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            data_out <= '0;
            data_vld <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            overrun <= 1'b0;
            // Consumer takes the word; a load below in the same cycle wins.
            if (data_vld && bus.rdy) begin
                data_vld <= 1'b0;
            end
            if (bus.s_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.s_in) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        // Shift in at the MSB so the first bit lands at bit 0.
                        shreg <= {bus.s_in, shreg[DATA_W-1:1]};
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PAR;
                        end
                    end
                    PAR: begin
                        par_bad <= bus.s_in ^ (^shreg);
                        state   <= STOP;
                    end
                    STOP: begin
                        // A 0 here is a framing error, never a new start bit.
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (bus.s_in) begin
                            if (!data_vld || bus.rdy) begin
                                data_out <= shreg;
                                par_err  <= par_bad;
                                data_vld <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_out = data_out;
    assign bus.data_vld = data_vld;
    assign bus.par_err  = par_err;
    assign bus.frm_err  = frm_err;
    assign bus.overrun  = overrun;
    assign bus.busy     = busy;
    assign dbg_state    = state;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames into serial_frame_rx, checked every
// cycle against a queue-based frame model plus literal expectations.
module tb_serial_frame_rx;
    localparam int DATA_W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Collects strobed bits after a start 0; once a full frame's worth is
    // gathered it is judged as a whole.
    logic [DATA_W-1:0] m_data = '0;
    logic              m_vld  = 1'b0;
    logic              m_par  = 1'b0;
    logic              m_frm  = 1'b0;
    logic              m_ovr  = 1'b0;
    logic              m_busy = 1'b0;
    bit                hunting = 1'b1;
    logic              bits[$];

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_data = '0; m_vld = 1'b0; m_par = 1'b0;
                m_frm = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
                hunting = 1'b1;
                bits.delete();
            end else begin
                automatic logic old_vld = m_vld;
                m_frm = 1'b0;
                m_ovr = 1'b0;
                if (m_vld && bus.rdy) m_vld = 1'b0;
                if (bus.s_en) begin
                    if (hunting) begin
                        if (bus.s_in == 1'b0) begin
                            hunting = 1'b0;
                            m_busy  = 1'b1;
                            bits.delete();
                        end
                    end else begin
                        bits.push_back(bus.s_in);
                        if (bits.size() == DATA_W + 2) begin
                            automatic int ones = 0;
                            automatic logic [DATA_W-1:0] w = '0;
                            for (int i = 0; i < DATA_W; i++) w[i] = bits[i];
                            for (int i = 0; i <= DATA_W; i++) ones += int'(bits[i]);
                            if (bits[DATA_W+1]) begin
                                if (!old_vld || bus.rdy) begin
                                    m_data = w;
                                    m_par  = (ones % 2) != 0;
                                    m_vld  = 1'b1;
                                end else begin
                                    m_ovr = 1'b1;
                                end
                            end else begin
                                m_frm = 1'b1;
                            end
                            hunting = 1'b1;
                            m_busy  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("data_vld", 32'(bus.data_vld), 32'(m_vld));
            check("data_out", 32'(bus.data_out), 32'(m_data));
            check("frm_err",  32'(bus.frm_err),  32'(m_frm));
            check("overrun",  32'(bus.overrun),  32'(m_ovr));
            check("busy",     32'(bus.busy),     32'(m_busy));
            if (m_vld || !reset_n) check("par_err", 32'(bus.par_err), 32'(m_par));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] make_frame(input logic [7:0] d, input logic flip, input logic stop);
        logic p;
        p = (^d) ^ flip;
        return {5'b0, stop, p, d, 1'b0};
    endfunction

    // Called at a negedge; sends n bits (bit 0 first), strobing every
    // stride-th cycle with junk on s_in in between. Returns at the negedge
    // after the last strobe's edge, line left idle high.
    task automatic send_bits(input logic [15:0] fb, input int n, input int stride);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < stride; k++) begin
                bus.s_en = (k == stride - 1);
                bus.s_in = (k == stride - 1) ? fb[i] : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        bus.s_en = 1'b1;
        bus.s_in = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] fa5;
        logic [15:0] f0f;
        fa5 = 16'h054A;   // 0,1,0,1,0,0,1,0,1,0,1
        f0f = 16'h041E;   // 0,1,1,1,1,0,0,0,0,0,1
        bus.s_en = 1'b1;
        bus.s_in = 1'b1;
        bus.rdy  = 1'b1;
        idle(3);
        check("reset data_vld", 32'(bus.data_vld), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        #2 reset_n = 1'b1;
        idle(2);

        // 1: plain 0xA5, rdy high
        send_bits(fa5, 11, 1);
        check("s1 data_out", 32'(bus.data_out), 32'hA5);
        check("s1 data_vld", 32'(bus.data_vld), 32'd1);
        check("s1 par_err", 32'(bus.par_err), 32'd0);
        check("s1 frm_err", 32'(bus.frm_err), 32'd0);
        idle(1);
        check("s1 vld drop", 32'(bus.data_vld), 32'd0);

        // 2: wrong parity, rdy low, held until rdy
        bus.rdy = 1'b0;
        send_bits(make_frame(8'hA5, 1'b1, 1'b1), 11, 1);
        check("s2 data_out", 32'(bus.data_out), 32'hA5);
        check("s2 par_err", 32'(bus.par_err), 32'd1);
        idle(3);
        check("s2 vld held", 32'(bus.data_vld), 32'd1);
        bus.rdy = 1'b1;
        idle(1);
        check("s2 vld drop", 32'(bus.data_vld), 32'd0);

        // 3: stop bit 0
        send_bits(make_frame(8'hA5, 1'b0, 1'b0), 11, 1);
        check("s3 frm_err", 32'(bus.frm_err), 32'd1);
        check("s3 data_vld", 32'(bus.data_vld), 32'd0);
        check("s3 busy", 32'(bus.busy), 32'd0);
        check("s3 state", 32'(dbg_state), 32'd0);
        idle(1);
        check("s3 frm pulse", 32'(bus.frm_err), 32'd0);
        idle(4);
        check("s3 idle busy", 32'(bus.busy), 32'd0);

        // 4: overrun on back-to-back frames
        bus.rdy = 1'b0;
        send_bits(fa5, 11, 1);
        send_bits(make_frame(8'h3C, 1'b0, 1'b1), 11, 1);
        check("s4 overrun", 32'(bus.overrun), 32'd1);
        check("s4 data_out", 32'(bus.data_out), 32'hA5);
        check("s4 data_vld", 32'(bus.data_vld), 32'd1);
        idle(1);
        check("s4 ovr pulse", 32'(bus.overrun), 32'd0);
        bus.rdy = 1'b1;
        idle(1);
        check("s4 vld drop", 32'(bus.data_vld), 32'd0);

        // 5: strobe every third cycle
        send_bits(fa5, 11, 3);
        check("s5 data_out", 32'(bus.data_out), 32'hA5);
        check("s5 data_vld", 32'(bus.data_vld), 32'd1);
        check("s5 par_err", 32'(bus.par_err), 32'd0);
        idle(2);

        // 6: reset mid-frame with a word held
        bus.rdy = 1'b0;
        send_bits(make_frame(8'h3C, 1'b0, 1'b1), 11, 1);
        send_bits(fa5, 5, 1);
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("s6 rst data_out", 32'(bus.data_out), 32'd0);
        check("s6 rst data_vld", 32'(bus.data_vld), 32'd0);
        check("s6 rst busy", 32'(bus.busy), 32'd0);
        check("s6 rst par_err", 32'(bus.par_err), 32'd0);
        #2 reset_n = 1'b1;
        bus.rdy = 1'b1;
        @(negedge clk);
        send_bits(f0f, 11, 1);
        check("s6 data_out", 32'(bus.data_out), 32'h0F);
        check("s6 par_err", 32'(bus.par_err), 32'd0);
        check("s6 data_vld", 32'(bus.data_vld), 32'd1);

        // 7: mixed frames, checked by the model only
        for (int f = 0; f < 10; f++) begin
            bus.rdy = 1'($urandom_range(0, 1));
            send_bits(make_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 3) != 0)), 11, $urandom_range(1, 2));
            idle($urandom_range(0, 2));
        end
        bus.rdy = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
